// File: rtl/riscv_pkg.sv
// Shared codes for the data-memory access controller: instruction classes,
// load/store size codes, controller state encoding and the legality check.
package riscv_pkg;

  // Instruction-class codes carried on req_type
  localparam logic [2:0] I_LOAD = 3'b000;
  localparam logic [2:0] I_ALU  = 3'b001;
  localparam logic [2:0] S_TYPE = 3'b010;
  localparam logic [2:0] B_TYPE = 3'b011;

  // funct3 size codes; bit 2 marks an unsigned load, bits [1:0] the size
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD        = 3'd1,
    RD_DATA   = 3'd2,
    WR        = 3'd3,
    RMW_RD    = 3'd4,
    RMW_MERGE = 3'd5,
    RMW_WR    = 3'd6,
    FAULT     = 3'd7
  } dmem_state_e;

  // True when funct3 is a legal size for the access kind and the byte
  // offset is naturally aligned for that size.
  function automatic logic access_legal(input logic is_store,
                                        input logic [2:0] f3,
                                        input logic [1:0] lane);
    logic f3_ok;
    logic aligned;
    if (is_store) f3_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else          f3_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                          (f3 == F3_BU) || (f3 == F3_HU);
    case (f3[1:0])
      2'b01:   aligned = ~lane[0];
      2'b10:   aligned = (lane == 2'b00);
      default: aligned = 1'b1;
    endcase
    return f3_ok & aligned;
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_lane.sv
// Lane steering for a word-wide memory: extracts and extends load data and
// builds the merged word for byte/half stores. Purely combinational.
module dmem_lane_unit
  import riscv_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  input  logic [31:0] rd_word,
  input  logic [15:0] st_data,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed lane, extend it, and splice store data into the word
  always_comb begin
    byte_sel = rd_word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (funct3[1:0])
      2'b00:   load_val = {{24{~funct3[2] & byte_sel[7]}}, byte_sel};
      2'b01:   load_val = {{16{~funct3[2] & half_sel[15]}}, half_sel};
      default: load_val = rd_word;
    endcase
    merged = rd_word;
    if (funct3[1:0] == 2'b00)      merged[{lane, 3'b000} +: 8]  = st_data[7:0];
    else if (funct3[1:0] == 2'b01) merged[{lane[1], 4'b0000} +: 16] = st_data;
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Sequencer between the MEM stage and a single-port synchronous-read data
// memory without byte enables: plain reads for loads, direct writes for sw,
// read-modify-write for sb/sh, and a no-access fault path.
//
// Handshake: a request is accepted on a rising clk2 edge where
// req_valid & req_ready; req_ready is high only in IDLE, and requests with
// an unsupported req_type are never accepted and never produce done.
// Completion is a one-cycle done pulse with rdata/err valid in that cycle.
module dmem_access_ctrl
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk2,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_type,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output dmem_state_e       dbg_state
);

  dmem_state_e       state_q, state_d;
  logic              accept;
  logic              is_load, is_store;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merged_q;
  logic [31:0]       load_val;
  logic [31:0]       merged;

  assign is_load   = (req_type == I_LOAD);
  assign is_store  = (req_type == S_TYPE);
  assign dbg_state = state_q;

  dmem_lane_unit u_lane (
    .lane     (addr_q[1:0]),
    .funct3   (funct3_q),
    .rd_word  (mem_rdata),
    .st_data  (wdata_q[15:0]),
    .load_val (load_val),
    .merged   (merged)
  );

  // State register; reset aborts any sequence in flight
  always_ff @(posedge clk2) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and memory strobes decoded from state and latched request
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    accept    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        accept    = req_valid & (is_load | is_store);
        if (accept) begin
          if (!access_legal(is_store, req_funct3, req_addr[1:0])) state_d = FAULT;
          else if (is_load)                                      state_d = RD;
          else if (req_funct3[1:0] == 2'b10)                     state_d = WR;
          else                                                   state_d = RMW_RD;
        end
      end
      RD: begin
        mem_en   = 1'b1;
        mem_addr = addr_q[ADDR_W-1:2];
        state_d  = RD_DATA;
      end
      RD_DATA: state_d = IDLE;
      WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q[ADDR_W-1:2];
        mem_wdata = wdata_q;
        state_d   = IDLE;
      end
      RMW_RD: begin
        mem_en   = 1'b1;
        mem_addr = addr_q[ADDR_W-1:2];
        state_d  = RMW_MERGE;
      end
      RMW_MERGE: state_d = RMW_WR;
      RMW_WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q[ADDR_W-1:2];
        mem_wdata = merged_q;
        state_d   = IDLE;
      end
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, merge/result registers and the registered done/err pulse
  always_ff @(posedge clk2) begin
    if (rst) begin
      addr_q   <= '0;
      funct3_q <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata    <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (accept) begin
        addr_q   <= req_addr;
        funct3_q <= req_funct3;
        wdata_q  <= req_wdata;
      end
      if (state_q == RMW_MERGE) merged_q <= merged;
      if (state_q == RD_DATA)   rdata    <= load_val;
      done <= (state_q == RD_DATA) || (state_q == WR) ||
              (state_q == RMW_WR)  || (state_q == FAULT);
      err  <= (state_q == FAULT);
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed scenarios plus random
// traffic, a byte-level reference model, and a done-triggered scoreboard.
module tb_dmem_access_ctrl;

  localparam logic [2:0] T_LOAD  = 3'b000;
  localparam logic [2:0] T_STORE = 3'b010;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] wword;
    logic [31:0] waddr;
    int          lat;
    int          acc;
    int          rd;
    int          wr;
    bit          chk_rdata;
    logic        err;
  } exp_t;

  // clock / reset
  logic clk2 = 1'b0;
  logic rst  = 1'b1;
  always #5 clk2 = ~clk2;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_type = '0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic        mem_en;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [2:0]  dbg_state;

  dmem_access_ctrl #(.ADDR_W(32)) dut (
    .clk2(clk2), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .done(done), .rdata(rdata), .err(err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk2) cyc <= cyc + 1;

  // memory model: synchronous read, write on strobe, backdoor poke port
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic        poke_en = 1'b0;
  logic [5:0]  poke_addr = '0;
  logic [31:0] poke_data = '0;

  always @(posedge clk2) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    if (mem_en && mem_we)  mem[mem_addr[5:0]] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[5:0]];
  end

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // monitor / scoreboard: counts strobes per operation, compares on done
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          wr_total = 0;
  logic [29:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;

  always @(negedge clk2) begin
    exp_t e;
    if (rst) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      if (mem_en && !mem_we) rd_cnt++;
      if (mem_en && mem_we) begin
        wr_cnt++;
        wr_total++;
        last_waddr = mem_addr;
        last_wdata = mem_wdata;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("err", {31'd0, err}, {31'd0, e.err});
          check("latency", cyc - e.acc + 1, e.lat);
          check("read_strobes", rd_cnt, e.rd);
          check("write_strobes", wr_cnt, e.wr);
          if (e.chk_rdata) check("rdata", rdata, e.rdata);
          if (e.wr > 0) begin
            check("wr_addr", {2'b00, last_waddr}, e.waddr);
            check("wr_data", last_wdata, e.wword);
          end
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  // reference model: byte-oriented view of the memory and access rules
  task automatic model_op(input logic [2:0] t, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output exp_t e);
    int          nb;
    int          off;
    bit          legal;
    logic [31:0] word;
    logic [31:0] val;
    logic [63:0] mask;
    logic [31:0] m32;
    nb  = 1 << f3[1:0];
    off = a % 4;
    if (t == T_LOAD) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    else             legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    if (legal && (off % nb != 0)) legal = 0;
    e = '{rdata: '0, wword: '0, waddr: a >> 2, lat: 2, acc: 0, rd: 0, wr: 0,
          chk_rdata: 0, err: 1'b1};
    if (!legal) return;
    e.err = 1'b0;
    word  = ref_mem[(a >> 2) % 64];
    if (t == T_LOAD) begin
      mask = (64'd1 << (8 * nb)) - 64'd1;
      m32  = mask[31:0];
      val  = (word >> (8 * off)) & m32;
      if (!f3[2] && nb < 4 && val[8*nb-1]) val = val | ~m32;
      e.rdata = val;
      e.chk_rdata = 1;
      e.lat = 3;
      e.rd  = 1;
    end else begin
      for (int i = 0; i < nb; i++) word[8*(off+i) +: 8] = wd[8*i +: 8];
      e.wword = word;
      e.wr    = 1;
      e.rd    = (nb == 4) ? 0 : 1;
      e.lat   = (nb == 4) ? 2 : 4;
      ref_mem[(a >> 2) % 64] = word;
    end
  endtask

  // driver tasks (called and returning at a negedge)
  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk2);
      n++;
    end
    if (!req_ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input logic [2:0] t, input logic [2:0] f3, input logic [7:0] a,
                      input logic [31:0] wd);
    exp_t e;
    bit   supported;
    wait_ready();
    supported  = (t == T_LOAD) || (t == T_STORE);
    req_valid  = 1'b1;
    req_type   = t;
    req_funct3 = f3;
    req_addr   = {24'd0, a};
    req_wdata  = wd;
    if (supported) begin
      model_op(t, f3, {24'd0, a}, wd, e);
      e.acc = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge clk2);
    req_valid  = 1'b0;
    req_type   = 3'($urandom_range(0, 7));
    req_funct3 = 3'($urandom_range(0, 7));
    req_addr   = $urandom;
    req_wdata  = $urandom;
    if (!supported) check("unsupported_not_accepted", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 200) begin
      @(negedge clk2);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
  endtask

  task automatic poke(input logic [5:0] wa, input logic [31:0] d);
    poke_en   = 1'b1;
    poke_addr = wa;
    poke_data = d;
    ref_mem[wa] = d;
    @(negedge clk2);
    poke_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_done"},      {31'd0, done},      32'd0);
    check({tag, "_err"},       {31'd0, err},       32'd0);
    check({tag, "_rdata"},     rdata,              32'd0);
    check({tag, "_mem_en"},    {31'd0, mem_en},    32'd0);
    check({tag, "_mem_we"},    {31'd0, mem_we},    32'd0);
    check({tag, "_mem_addr"},  {2'b00, mem_addr},  32'd0);
    check({tag, "_mem_wdata"}, mem_wdata,          32'd0);
  endtask

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // stimulus
  initial begin
    logic [2:0]  t;
    logic [2:0]  f3;
    logic [7:0]  a;
    int          wr_before;
    int          k;
    logic [2:0]  legal_f3 [5];
    legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    @(negedge clk2);
    for (int i = 0; i < 64; i++) poke(6'(i), $urandom);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk2);

    // lw at 0x40
    poke(6'h10, 32'h8899AABB);
    send(T_LOAD, 3'b010, 8'h40, 32'h0);
    drain();
    // lb / lbu / lh back-to-back on one word
    poke(6'h10, 32'h80112233);
    send(T_LOAD, 3'b000, 8'h43, 32'h0);
    send(T_LOAD, 3'b100, 8'h43, 32'h0);
    send(T_LOAD, 3'b001, 8'h42, 32'h0);
    drain();
    check("lh_literal", exp_q.size(), 32'd0);
    // sb then sh read-modify-write
    poke(6'h10, 32'h11223344);
    send(T_STORE, 3'b000, 8'h41, 32'hFFFFFF5A);
    send(T_STORE, 3'b001, 8'h42, 32'h1234BEEF);
    drain();
    @(negedge clk2);
    check("sb_sh_word", mem[6'h10], 32'hBEEF5A44);
    // faults: misaligned sw, illegal load funct3, unsupported types
    send(T_STORE, 3'b010, 8'h46, 32'hDEADBEEF);
    send(T_LOAD, 3'b011, 8'h40, 32'h0);
    send(3'b011, 3'b010, 8'h40, 32'h0);
    send(3'b110, 3'b000, 8'h44, 32'h0);
    // back-to-back lw then sw
    send(T_LOAD, 3'b010, 8'h44, 32'h0);
    send(T_STORE, 3'b010, 8'h48, 32'hCAFEF00D);
    send(T_LOAD, 3'b010, 8'h48, 32'h0);
    drain();

    // reset during RMW_MERGE of an sb
    poke(6'h10, 32'h11223344);
    wr_before  = wr_total;
    k          = cyc;
    req_valid  = 1'b1;
    req_type   = T_STORE;
    req_funct3 = 3'b000;
    req_addr   = 32'h41;
    req_wdata  = 32'h5A;
    @(negedge clk2);
    req_valid = 1'b0;
    @(negedge clk2);
    check("abort_timing", cyc - k, 32'd2);
    rst = 1'b1;
    @(negedge clk2);
    check_reset_outputs("abort");
    rst = 1'b0;
    repeat (3) @(negedge clk2);
    check("abort_no_write", wr_total - wr_before, 32'd0);
    check("abort_mem_word", mem[6'h10], 32'h11223344);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 9);
      if (k == 0) begin
        t = 3'($urandom_range(3, 7));
      end else begin
        t = (k <= 5) ? T_LOAD : T_STORE;
      end
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
      else if (t == T_LOAD)          f3 = legal_f3[$urandom_range(0, 4)];
      else                           f3 = 3'($urandom_range(0, 2));
      a = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0) begin
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      send(t, f3, a, $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk2);
    end
    drain();
    repeat (2) @(negedge clk2);

    for (int i = 0; i < 64; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Sequencing controller between the MEM pipeline stage and a single-port, word-wide, synchronous-read data memory with no byte enables. Accepts one load/store request at a time and runs multi-cycle memory sequences: plain read for loads, direct write for sw, and read-modify-write for sb/sh. Handles lane selection, sign/zero extension and alignment checks. Signals completion with a one-cycle done pulse so the MEM stage can hold the pipeline until then.

Parameters:
ADDR_W, 32, byte-address width; memory word address is addr[ADDR_W-1:2]

Ports:
clk2  input  1  pipeline clock; all state changes on posedge clk2
rst  input  1  synchronous active-high reset
req_valid  input  1  MEM stage has a memory operation
req_ready  output  1  controller idle and can accept; accept = req_valid & req_ready
req_type  input  3  instruction class; 3'b000 I_load, 3'b010 S_type; other codes ignored (never accepted)
req_funct3  input  3  IR[14:12]: 000 b, 001 h, 010 w, 100 bu, 101 hu
req_addr  input  ADDR_W  byte address (ALU result)
req_wdata  input  32  store data (rs2)
done  output  1  one-cycle pulse: operation finished, rdata/err valid
rdata  output  32  extended load result, held until next done
err  output  1  valid with done: misaligned access or illegal funct3, no memory access performed
mem_en  output  1  memory access strobe
mem_we  output  1  write when mem_en=1
mem_addr  output  ADDR_W-2  word address
mem_wdata  output  32  write word
mem_rdata  input  32  read word, valid the cycle after a read strobe

Behaviour:
- Reset: state IDLE; req_ready=1; done=0, err=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0. Reset mid-operation aborts the sequence. No mem_we is issued after reset is asserted, even if an RMW write was pending.
- States: IDLE, RD, RD_DATA, WR, RMW_RD, RMW_MERGE, RMW_WR, FAULT.
- Accept only in IDLE. Latch type, funct3, addr and wdata in internal registers. Inputs are don't-care after acceptance.
- Alignment check at accept: h/hu/sh require addr[0]=0; w requires addr[1:0]=00. Loads allow funct3 000/001/010/100/101; stores allow 000/001/010. Anything else goes to FAULT.
- Transitions:
  - From IDLE on accept: load -> RD; sw -> WR; sb/sh -> RMW_RD; fault -> FAULT.
  - RD -> RD_DATA -> IDLE.
  - WR -> IDLE.
  - RMW_RD -> RMW_MERGE -> RMW_WR -> IDLE.
  - FAULT -> IDLE.
- mem_en/mem_we/mem_addr/mem_wdata are decoded combinationally from state and latched registers:
  - RD and RMW_RD: en=1, we=0.
  - WR and RMW_WR: en=1, we=1.
  - All other states: en=0, we=0.
- Load extract in RD_DATA: lane=addr[1:0].
  - b/bu: byte mem_rdata[8*lane+7 : 8*lane], sign/zero extended.
  - h/hu: half at addr[1] (bits [15:0] or [31:16]), extended.
  - w: full word.
  - Result is registered into rdata at the end of RD_DATA.
- RMW_MERGE: register merged word = mem_rdata with the addressed byte/half replaced by wdata[7:0]/wdata[15:0]. Untouched lanes are preserved bit-exact. RMW_WR writes this merged word.
- done (registered) pulses in the cycle after leaving RD_DATA, WR, RMW_WR or FAULT. err=1 only with a FAULT done; err is 0 with every other done.
- Latency, accept edge to done-high cycle:
  - load: 3 cycles
  - sw: 2 cycles
  - sb/sh: 4 cycles
  - fault: 2 cycles
- req_ready=1 only in IDLE. A new request is acceptable in the same cycle done is high (back-to-back).
- req_valid with an unsupported req_type: not accepted, no done pulse; MEM stage must not wait on it.

Decomposition:
- Shared package (riscv_pkg): instruction-class codes (I_load=3'b000, S_type=3'b010, etc.), funct3 load/store size codes, controller state encoding.
- One natural sub-module: dmem_lane_unit. Purely combinational; given lane, funct3, mem_rdata and wdata it produces the extended load value and the merged store word. Shared by RD_DATA and RMW_MERGE.

Test Plan:
- lw at 0x40 where mem[0x10]=0x8899AABB: done 3 cycles after accept, rdata=0x8899AABB, err=0, exactly one read strobe with mem_addr=0x10.
- lb/lbu at 0x43 where word=0x80112233: lb rdata=0xFFFFFF80, lbu rdata=0x00000080; lh at 0x42 returns 0xFFFF8011.
- sb 0x5A at 0x41 where word=0x11223344: one read then one write of 0x11225A44; sh 0xBEEF at 0x42 writes 0xBEEF5A44; done 4 cycles after accept.
- sw at 0x46 (misaligned) and lw with funct3=011: done 2 cycles after accept with err=1, mem_en never asserted.
- Reset asserted in RMW_MERGE of an sb: no mem_we pulse, all outputs at reset values next cycle, req_ready=1; memory word unchanged.
- Back-to-back: sw accepted in the cycle done of the previous lw is high; both complete with correct data and no dropped or duplicated strobes.
